// File: rtl/param_stream_loader.sv
// Parameter-load sequencer: walks the layer-descriptor table, fetches record words from external
// memory and streams them to each CiM as one start op followed by packed data ops.
module param_stream_loader #(
  parameter int unsigned N_STORAGE    = 16,
  parameter int unsigned NUM_CIMS     = 64,
  parameter int unsigned NUM_LAYERS   = 10,
  parameter int unsigned MAX_LEN      = 64,
  parameter int unsigned EXT_ADDR_W   = 15,
  parameter int unsigned CIM_ADDR_W   = 10,
  parameter int unsigned WORDS_PER_OP = 3,
  parameter int unsigned BUS_OP_WIDTH = 4,
  parameter logic [BUS_OP_WIDTH-1:0] OP_START = BUS_OP_WIDTH'(1),
  parameter logic [BUS_OP_WIDTH-1:0] OP_DATA  = BUS_OP_WIDTH'(2),
  parameter logic [BUS_OP_WIDTH-1:0] OP_NOP   = BUS_OP_WIDTH'(0),
  localparam int unsigned LW  = $clog2(MAX_LEN + 1),
  localparam int unsigned RW  = $clog2(NUM_CIMS + 1),
  localparam int unsigned TW  = $clog2(NUM_CIMS),
  localparam int unsigned CLW = $clog2(NUM_LAYERS)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             abort,
  input  logic [NUM_LAYERS*EXT_ADDR_W-1:0] layer_base,
  input  logic [NUM_LAYERS*LW-1:0]         layer_len,
  input  logic [NUM_LAYERS*RW-1:0]         layer_num_rec,
  input  logic [NUM_LAYERS*CIM_ADDR_W-1:0] layer_cim_addr,
  output logic [EXT_ADDR_W-1:0]            ext_mem_addr,
  output logic                             ext_mem_rd,
  input  logic                             ext_mem_data_valid,
  input  logic [N_STORAGE-1:0]             ext_mem_data,
  input  logic                             bus_ready,
  output logic                             bus_drive,
  output logic [BUS_OP_WIDTH-1:0]          bus_op,
  output logic [3*N_STORAGE-1:0]           bus_data,
  output logic [TW-1:0]                    bus_target,
  output logic                             busy,
  output logic                             done,
  output logic [CLW-1:0]                   cur_layer
);

  typedef enum logic [2:0] {StIdle, StSetup, StStart, StFetch, StWait, StSend, StFin} state_e;

  state_e                state_q;
  logic [LW-1:0]         len_q;
  logic [LW-1:0]         word_q;
  logic [RW-1:0]         nrec_q;
  logic [RW-1:0]         rec_q;
  logic [CIM_ADDR_W-1:0] cim_q;
  logic [EXT_ADDR_W-1:0] ptr_q;
  logic [1:0]            slot_q;
  logic [N_STORAGE-1:0]  slot_data_q [3];

  logic [EXT_ADDR_W-1:0] base_arr [NUM_LAYERS];
  logic [LW-1:0]         len_arr  [NUM_LAYERS];
  logic [RW-1:0]         nrec_arr [NUM_LAYERS];
  logic [CIM_ADDR_W-1:0] cim_arr  [NUM_LAYERS];
  logic [NUM_LAYERS-1:0] nonempty;

  always_comb begin
    for (int l = 0; l < NUM_LAYERS; l++) begin
      base_arr[l] = layer_base[l*EXT_ADDR_W +: EXT_ADDR_W];
      len_arr[l]  = layer_len[l*LW +: LW];
      nrec_arr[l] = layer_num_rec[l*RW +: RW];
      cim_arr[l]  = layer_cim_addr[l*CIM_ADDR_W +: CIM_ADDR_W];
      nonempty[l] = (nrec_arr[l] != '0) && (len_arr[l] != '0);
    end
  end

  logic last_word, last_rec, last_layer, slot_full, more_layers, sel_empty;
  logic [3*N_STORAGE-1:0] merged;

  assign last_word  = (word_q == len_q - LW'(1));
  assign last_rec   = (rec_q == nrec_q - RW'(1));
  assign last_layer = (cur_layer == CLW'(NUM_LAYERS - 1));
  assign slot_full  = (slot_q == 2'(WORDS_PER_OP - 1));
  assign sel_empty  = !nonempty[cur_layer];

  // Lets bus_drive drop right after the final op when only empty layers remain.
  always_comb begin
    more_layers = 1'b0;
    for (int l = 0; l < NUM_LAYERS; l++) begin
      if (l > int'(cur_layer) && nonempty[l]) more_layers = 1'b1;
    end
  end

  always_comb begin
    merged = '0;
    for (int k = 0; k < 3; k++) begin
      merged[k*N_STORAGE +: N_STORAGE] = (slot_q == 2'(k)) ? ext_mem_data : slot_data_q[k];
    end
  end

  function automatic logic [3*N_STORAGE-1:0] start_payload(input logic [LW-1:0] len,
                                                          input logic [CIM_ADDR_W-1:0] cim);
    return {N_STORAGE'(0), N_STORAGE'(len), N_STORAGE'(cim)};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      len_q        <= '0;
      word_q       <= '0;
      nrec_q       <= '0;
      rec_q        <= '0;
      cim_q        <= '0;
      ptr_q        <= '0;
      slot_q       <= '0;
      for (int k = 0; k < 3; k++) slot_data_q[k] <= '0;
      ext_mem_addr <= '0;
      ext_mem_rd   <= 1'b0;
      bus_drive    <= 1'b0;
      bus_op       <= OP_NOP;
      bus_data     <= '0;
      bus_target   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      cur_layer    <= '0;
    end else if (abort) begin
      state_q    <= StIdle;
      ext_mem_rd <= 1'b0;
      bus_drive  <= 1'b0;
      bus_op     <= OP_NOP;
      bus_data   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            state_q   <= StSetup;
            busy      <= 1'b1;
            cur_layer <= '0;
          end
        end
        StSetup: begin
          len_q  <= len_arr[cur_layer];
          nrec_q <= nrec_arr[cur_layer];
          cim_q  <= cim_arr[cur_layer];
          ptr_q  <= base_arr[cur_layer];
          rec_q  <= '0;
          if (sel_empty) begin
            if (last_layer) begin
              state_q   <= StFin;
              done      <= 1'b1;
              busy      <= 1'b0;
              bus_drive <= 1'b0;
            end else begin
              cur_layer <= cur_layer + CLW'(1);
            end
          end else begin
            state_q    <= StStart;
            bus_drive  <= 1'b1;
            bus_op     <= OP_START;
            bus_target <= '0;
            bus_data   <= start_payload(len_arr[cur_layer], cim_arr[cur_layer]);
          end
        end
        StStart: begin
          if (bus_ready) begin
            bus_op       <= OP_NOP;
            bus_data     <= '0;
            word_q       <= '0;
            slot_q       <= '0;
            for (int k = 0; k < 3; k++) slot_data_q[k] <= '0;
            ext_mem_rd   <= 1'b1;
            ext_mem_addr <= ptr_q;
            ptr_q        <= ptr_q + EXT_ADDR_W'(1);
            state_q      <= StFetch;
          end
        end
        StFetch: begin
          ext_mem_rd <= 1'b0;
          state_q    <= StWait;
        end
        StWait: begin
          if (ext_mem_data_valid) begin
            if (slot_full || last_word) begin
              state_q    <= StSend;
              bus_op     <= OP_DATA;
              bus_data   <= merged;
              bus_target <= TW'(rec_q);
              for (int k = 0; k < 3; k++) slot_data_q[k] <= '0;
            end else begin
              slot_data_q[slot_q] <= ext_mem_data;
              slot_q       <= slot_q + 2'd1;
              word_q       <= word_q + LW'(1);
              ext_mem_rd   <= 1'b1;
              ext_mem_addr <= ptr_q;
              ptr_q        <= ptr_q + EXT_ADDR_W'(1);
              state_q      <= StFetch;
            end
          end
        end
        StSend: begin
          if (bus_ready) begin
            bus_op   <= OP_NOP;
            bus_data <= '0;
            if (!last_word) begin
              word_q       <= word_q + LW'(1);
              slot_q       <= '0;
              ext_mem_rd   <= 1'b1;
              ext_mem_addr <= ptr_q;
              ptr_q        <= ptr_q + EXT_ADDR_W'(1);
              state_q      <= StFetch;
            end else if (!last_rec) begin
              rec_q      <= rec_q + RW'(1);
              bus_op     <= OP_START;
              bus_target <= TW'(rec_q + RW'(1));
              bus_data   <= start_payload(len_q, cim_q);
              state_q    <= StStart;
            end else if (!last_layer && more_layers) begin
              cur_layer <= cur_layer + CLW'(1);
              state_q   <= StSetup;
            end else begin
              state_q   <= StFin;
              done      <= 1'b1;
              busy      <= 1'b0;
              bus_drive <= 1'b0;
            end
          end
        end
        StFin: begin
          done      <= 1'b0;
          bus_drive <= 1'b0;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_param_stream_loader.sv
// Directed bench for param_stream_loader: memory model with configurable latency, bus monitor,
// hand-built expected op and read lists.
module tb_param_stream_loader;
  localparam int NL = 10, EW = 15, LW = 7, RW = 7, CW = 10, NS = 16, TW = 6, CLW = 4;
  localparam logic [3:0] OP_NOP = 4'h0, OP_START = 4'h1, OP_DATA = 4'h2;

  typedef struct packed {
    logic [3:0]      op;
    logic [TW-1:0]   tgt;
    logic [3*NS-1:0] data;
  } op_t;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic start = 1'b0, abort = 1'b0, bus_ready = 1'b1;
  logic [NL*EW-1:0] layer_base = '0;
  logic [NL*LW-1:0] layer_len = '0;
  logic [NL*RW-1:0] layer_num_rec = '0;
  logic [NL*CW-1:0] layer_cim_addr = '0;
  logic [EW-1:0] ext_mem_addr;
  logic ext_mem_rd;
  logic mem_valid = 1'b0;
  logic [NS-1:0] mem_data = '0;
  logic bus_drive, busy, done;
  logic [3:0] bus_op;
  logic [3*NS-1:0] bus_data;
  logic [TW-1:0] bus_target;
  logic [CLW-1:0] cur_layer;

  logic start2 = 1'b0;
  logic [NL*EW-1:0] base2 = '0;
  logic [NL*LW-1:0] len2 = '0;
  logic [NL*RW-1:0] nrec2 = '0;
  logic [NL*CW-1:0] cim2 = '0;
  logic [EW-1:0] addr2;
  logic rd2, drive2, busy2, done2;
  logic valid2 = 1'b0;
  logic [NS-1:0] data2 = '0;
  logic [3:0] op2;
  logic [3*NS-1:0] bdata2;
  logic [TW-1:0] tgt2;
  logic [CLW-1:0] layer2;

  param_stream_loader #(.WORDS_PER_OP(3), .OP_START(OP_START), .OP_DATA(OP_DATA),
                        .OP_NOP(OP_NOP)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .layer_base(layer_base), .layer_len(layer_len), .layer_num_rec(layer_num_rec),
    .layer_cim_addr(layer_cim_addr), .ext_mem_addr(ext_mem_addr), .ext_mem_rd(ext_mem_rd),
    .ext_mem_data_valid(mem_valid), .ext_mem_data(mem_data), .bus_ready(bus_ready),
    .bus_drive(bus_drive), .bus_op(bus_op), .bus_data(bus_data), .bus_target(bus_target),
    .busy(busy), .done(done), .cur_layer(cur_layer)
  );

  param_stream_loader #(.WORDS_PER_OP(1), .OP_START(OP_START), .OP_DATA(OP_DATA),
                        .OP_NOP(OP_NOP)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(1'b0),
    .layer_base(base2), .layer_len(len2), .layer_num_rec(nrec2),
    .layer_cim_addr(cim2), .ext_mem_addr(addr2), .ext_mem_rd(rd2),
    .ext_mem_data_valid(valid2), .ext_mem_data(data2), .bus_ready(1'b1),
    .bus_drive(drive2), .bus_op(op2), .bus_data(bdata2), .bus_target(tgt2),
    .busy(busy2), .done(done2), .cur_layer(layer2)
  );

  function automatic logic [NS-1:0] memf(input logic [EW-1:0] a);
    return {1'b1, a};
  endfunction

  // External memory models
  int lat = 1;
  int pend_cnt = 0;
  logic [EW-1:0] pend_addr = '0;
  always @(posedge clk) begin
    mem_valid <= 1'b0;
    if (pend_cnt == 1) begin
      mem_valid <= 1'b1;
      mem_data  <= memf(pend_addr);
    end
    if (pend_cnt != 0) pend_cnt <= pend_cnt - 1;
    if (ext_mem_rd) begin
      if (lat <= 1) begin
        mem_valid <= 1'b1;
        mem_data  <= memf(ext_mem_addr);
      end else begin
        pend_cnt  <= lat - 1;
        pend_addr <= ext_mem_addr;
      end
    end
  end

  always @(posedge clk) begin
    valid2 <= rd2;
    data2  <= memf(addr2);
  end

  // Monitor
  op_t ops_q[$], ops2_q[$], exp_q[$];
  logic [EW-1:0] rd_q[$], exp_rd[$];
  logic [CLW-1:0] layer_q[$];
  int done_cnt = 0, done2_cnt = 0;
  always @(posedge clk) begin
    if (bus_drive && bus_ready && bus_op != OP_NOP) ops_q.push_back({bus_op, bus_target, bus_data});
    if (ext_mem_rd) rd_q.push_back(ext_mem_addr);
    if (done) done_cnt <= done_cnt + 1;
    if (busy && (layer_q.size() == 0 || layer_q[$] != cur_layer)) layer_q.push_back(cur_layer);
    if (drive2 && op2 != OP_NOP) ops2_q.push_back({op2, tgt2, bdata2});
    if (done2) done2_cnt <= done2_cnt + 1;
  end

  int checks = 0, passes = 0, fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_op(input logic [3:0] op, input int tgt, input logic [NS-1:0] d2,
                         input logic [NS-1:0] d1, input logic [NS-1:0] d0);
    exp_q.push_back({op, TW'(tgt), d2, d1, d0});
  endtask

  task automatic set_layer(input int l, input int base, input int len, input int nrec,
                           input int cim);
    layer_base[l*EW +: EW]     = EW'(base);
    layer_len[l*LW +: LW]      = LW'(len);
    layer_num_rec[l*RW +: RW]  = RW'(nrec);
    layer_cim_addr[l*CW +: CW] = CW'(cim);
  endtask

  task automatic clear_tables();
    layer_base = '0; layer_len = '0; layer_num_rec = '0; layer_cim_addr = '0;
  endtask

  task automatic clear_mon();
    ops_q.delete(); rd_q.delete(); layer_q.delete(); exp_q.delete(); exp_rd.delete();
  endtask

  // One layer, len 5, two records, three words per op
  task automatic build_t1(input int base, input int cim);
    exp_q.delete(); exp_rd.delete();
    for (int r = 0; r < 2; r++) begin
      int b = base + 5 * r;
      push_op(OP_START, r, 16'h0, 16'd5, NS'(cim));
      push_op(OP_DATA, r, memf(EW'(b + 2)), memf(EW'(b + 1)), memf(EW'(b)));
      push_op(OP_DATA, r, 16'h0, memf(EW'(b + 4)), memf(EW'(b + 3)));
    end
    for (int k = 0; k < 10; k++) exp_rd.push_back(EW'(base + k));
  endtask

  task automatic compare_ops(input string tag);
    check({tag, "_nops"}, ops_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < ops_q.size(); i++)
      check($sformatf("%s_op%0d", tag, i), ops_q[i], exp_q[i]);
    check({tag, "_nrd"}, rd_q.size(), exp_rd.size());
    for (int i = 0; i < exp_rd.size() && i < rd_q.size(); i++)
      check($sformatf("%s_rd%0d", tag, i), rd_q[i], exp_rd[i]);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic run_to_idle(input string tag);
    int n = 0;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, n >= 400, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_data(input string tag);
    int n = 0;
    while (bus_op !== OP_DATA && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_wait_data"}, n >= 100, 0);
  endtask

  initial begin
    op_t snap;
    int rdn, opn, dn, n;
    logic stable;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ctrl", {busy, done, bus_drive, ext_mem_rd, bus_op, bus_target, cur_layer}, 0);
    check("rst_data", bus_data, 0);
    rst_n = 1'b1;

    // 1: basic load
    clear_tables();
    set_layer(0, 100, 5, 2, 42);
    clear_mon();
    @(negedge clk) start = 1'b1;
    check("t1_busy_before", busy, 0);
    @(negedge clk) start = 1'b0;
    check("t1_busy_rise", busy, 1);
    run_to_idle("t1");
    build_t1(100, 42);
    compare_ops("t1");
    check("t1_done", done_cnt, 1);
    check("t1_drive_end", bus_drive, 0);

    // 2: backpressure during SEND
    clear_mon();
    pulse_start();
    wait_data("bp");
    bus_ready = 1'b0;
    snap = {bus_op, bus_target, bus_data};
    rdn = rd_q.size();
    opn = ops_q.size();
    stable = 1'b1;
    repeat (7) begin
      @(negedge clk);
      if ({bus_op, bus_target, bus_data} !== snap || ext_mem_rd !== 1'b0) stable = 1'b0;
    end
    check("bp_stable", stable, 1);
    check("bp_hold_op", bus_op, OP_DATA);
    check("bp_no_rd", rd_q.size(), rdn);
    check("bp_no_op", ops_q.size(), opn);
    bus_ready = 1'b1;
    run_to_idle("bp");
    build_t1(100, 42);
    compare_ops("bp");
    check("bp_done", done_cnt, 2);

    // 3: empty middle layer
    clear_tables();
    set_layer(0, 200, 2, 1, 1);
    set_layer(1, 300, 4, 0, 5);
    set_layer(2, 400, 1, 2, 3);
    clear_mon();
    pulse_start();
    run_to_idle("sk");
    push_op(OP_START, 0, 16'h0, 16'd2, 16'd1);
    push_op(OP_DATA, 0, 16'h0, memf(15'd201), memf(15'd200));
    push_op(OP_START, 0, 16'h0, 16'd1, 16'd3);
    push_op(OP_DATA, 0, 16'h0, 16'h0, memf(15'd400));
    push_op(OP_START, 1, 16'h0, 16'd1, 16'd3);
    push_op(OP_DATA, 1, 16'h0, 16'h0, memf(15'd401));
    exp_rd.push_back(15'd200); exp_rd.push_back(15'd201);
    exp_rd.push_back(15'd400); exp_rd.push_back(15'd401);
    compare_ops("sk");
    check("sk_nlayers", layer_q.size() >= 3, 1);
    for (int i = 0; i < 3 && i < layer_q.size(); i++)
      check($sformatf("sk_layer%0d", i), layer_q[i], i);
    check("sk_done", done_cnt, 3);

    // 4: one word per op
    base2[EW-1:0] = 15'd50;
    len2[LW-1:0]  = 7'd2;
    nrec2[RW-1:0] = 7'd1;
    cim2[CW-1:0]  = 10'd7;
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    n = 0;
    while (busy2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("w1_timeout", n >= 200, 0);
    repeat (2) @(negedge clk);
    check("w1_nops", ops2_q.size(), 3);
    if (ops2_q.size() == 3) begin
      check("w1_start", ops2_q[0], {OP_START, 6'd0, 16'h0, 16'd2, 16'd7});
      check("w1_d0", ops2_q[1], {OP_DATA, 6'd0, 16'h0, 16'h0, memf(15'd50)});
      check("w1_d1", ops2_q[2], {OP_DATA, 6'd0, 16'h0, 16'h0, memf(15'd51)});
    end
    check("w1_done", done2_cnt, 1);

    // 5: abort in WAIT with a late response
    clear_tables();
    set_layer(0, 100, 5, 2, 42);
    clear_mon();
    lat = 4;
    pulse_start();
    n = 0;
    while (ext_mem_rd !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ab_wait_rd", n >= 50, 0);
    @(negedge clk) abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    check("ab_drive", bus_drive, 0);
    check("ab_busy", busy, 0);
    repeat (6) @(negedge clk);
    check("ab_idle", {busy, bus_drive, bus_op, ext_mem_rd}, 0);
    check("ab_nops", ops_q.size(), 1);
    check("ab_nrd", rd_q.size(), 1);
    check("ab_no_done", done_cnt, 3);
    // start together with abort stays idle
    @(negedge clk) begin start = 1'b1; abort = 1'b1; end
    @(negedge clk) begin start = 1'b0; abort = 1'b0; end
    repeat (2) @(negedge clk);
    check("sa_idle", {busy, ext_mem_rd}, 0);
    check("sa_nrd", rd_q.size(), 1);
    lat = 1;
    clear_mon();
    pulse_start();
    run_to_idle("rs");
    build_t1(100, 42);
    compare_ops("rs");
    check("rs_done", done_cnt, 4);

    // 6: start while busy is ignored
    clear_mon();
    pulse_start();
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    run_to_idle("sb");
    build_t1(100, 42);
    compare_ops("sb");
    check("sb_done", done_cnt, 5);

    // Reset in the middle of SEND
    pulse_start();
    wait_data("rm");
    bus_ready = 1'b0;
    @(negedge clk);
    dn = done_cnt;
    rst_n = 1'b0;
    #1;
    check("rm_ctrl", {busy, done, bus_drive, ext_mem_rd, bus_op, bus_target, cur_layer}, 0);
    check("rm_data", bus_data, 0);
    check("rm_addr", ext_mem_addr, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bus_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rm_no_done", done_cnt, dn);
    check("rm_idle", busy, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
